// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: UART framing controller; RX hunts a header and assembles operands, TX serialises a result MSB-byte-first.
module uart_frame_ctrl #(
  parameter logic [7:0]  HDR       = 8'h0A,
  parameter int          N_IN      = 2,
  parameter int          IN_BYTES  = 1,
  parameter int          OUT_BYTES = 1,
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter int          EN_LEN    = 3
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_status,
  input  logic                          tx_status,
  input  logic [OUT_BYTES*8-1:0]        out_data,
  input  logic                          out_valid,
  output logic                          out_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_en,
  output logic [N_IN*IN_BYTES*8-1:0]    in_data,
  output logic                          in_valid,
  output logic                          frame_err
);
  localparam int          IW       = N_IN*IN_BYTES*8;
  localparam int          OW       = OUT_BYTES*8;
  localparam logic [5:0]  CNT_LAST = 6'(N_IN*IN_BYTES-1);
  localparam logic [15:0] TMR_LAST = TIMEOUT - 16'd1;
  localparam logic [2:0]  K_LAST   = 3'(OUT_BYTES-1);
  localparam logic [2:0]  P_LAST   = 3'(EN_LEN-1);

  typedef enum logic {R_HUNT, R_DATA} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_PULSE, T_WAIT} tx_state_e;

  rx_state_e   rx_q, rx_d;
  logic        rx_status_q;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [IW-1:0] shadow_q, shadow_d, in_data_q, in_data_d;
  logic        in_valid_q, in_valid_d, frame_err_q, frame_err_d;
  logic        rx_byte;

  tx_state_e   tx_q, tx_d;
  logic [OW-1:0] out_q, out_d;
  logic [2:0]  k_q, k_d, p_q, p_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;

  assign rx_byte   = rx_status & ~rx_status_q;
  assign out_ready = (tx_q == T_IDLE);
  assign tx_data   = tx_data_q;
  assign tx_en     = tx_en_q;
  assign in_data   = in_data_q;
  assign in_valid  = in_valid_q;
  assign frame_err = frame_err_q;

  // A header seen inside a frame is ordinary data; only R_HUNT looks for HDR.
  always_comb begin
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    shadow_d    = shadow_q;
    in_data_d   = in_data_q;
    in_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (rx_q == R_HUNT) begin
      if (rx_byte && rx_data == HDR) begin
        rx_d    = R_DATA;
        cnt_d   = '0;
        timer_d = '0;
      end
    end else if (rx_byte) begin
      shadow_d = IW'({shadow_q, rx_data});
      cnt_d    = cnt_q + 6'd1;
      timer_d  = '0;
      if (cnt_q == CNT_LAST) begin
        in_data_d  = IW'({shadow_q, rx_data});
        in_valid_d = 1'b1;
        rx_d       = R_HUNT;
      end
    end else if (TIMEOUT != 16'd0) begin
      if (timer_q == TMR_LAST) begin
        frame_err_d = 1'b1;
        rx_d        = R_HUNT;
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end
  end

  // The latched result shifts left so the byte being sent is always the top byte.
  always_comb begin
    tx_d      = tx_q;
    out_d     = out_q;
    k_d       = k_q;
    p_d       = p_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    case (tx_q)
      T_IDLE:
        if (out_valid) begin
          out_d = out_data;
          k_d   = '0;
          tx_d  = T_SEND;
        end
      T_SEND:
        if (tx_status) begin
          tx_data_d = out_q[OW-1 -: 8];
          tx_en_d   = 1'b1;
          p_d       = '0;
          tx_d      = T_PULSE;
        end
      T_PULSE:
        if (p_q == P_LAST) begin
          tx_en_d = 1'b0;
          tx_d    = T_WAIT;
        end else begin
          p_d = p_q + 3'd1;
        end
      T_WAIT:
        if (!tx_status) begin
          tx_d  = (k_q == K_LAST) ? T_IDLE : T_SEND;
          k_d   = (k_q == K_LAST) ? k_q : k_q + 3'd1;
          out_d = (k_q == K_LAST) ? out_q : out_q << 8;
        end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_q        <= R_HUNT;
      rx_status_q <= 1'b0;
      cnt_q       <= '0;
      timer_q     <= '0;
      shadow_q    <= '0;
      in_data_q   <= '0;
      in_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_q        <= T_IDLE;
      out_q       <= '0;
      k_q         <= '0;
      p_q         <= '0;
      tx_data_q   <= '0;
      tx_en_q     <= 1'b0;
    end else begin
      rx_q        <= rx_d;
      rx_status_q <= rx_status;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      shadow_q    <= shadow_d;
      in_data_q   <= in_data_d;
      in_valid_q  <= in_valid_d;
      frame_err_q <= frame_err_d;
      tx_q        <= tx_d;
      out_q       <= out_d;
      k_q         <= k_d;
      p_q         <= p_d;
      tx_data_q   <= tx_data_d;
      tx_en_q     <= tx_en_d;
    end
  end
endmodule
